// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback (always wins)
// and a small FIFO of multiply/divide results, with a starvation timer that requests a stall.
module regfile_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          wb_valid,
    input  logic [ADDR_W-1:0]             wb_addr,
    input  logic [DATA_W-1:0]             wb_data,
    input  logic                          mdu_valid,
    output logic                          mdu_ready,
    input  logic [ADDR_W-1:0]             mdu_addr,
    input  logic [DATA_W-1:0]             mdu_data,
    output logic                          rf_write_enable,
    output logic [ADDR_W-1:0]             rf_write_address,
    output logic [DATA_W-1:0]             rf_write_data,
    input  logic [ADDR_W-1:0]             busy_addr_1,
    input  logic [ADDR_W-1:0]             busy_addr_2,
    output logic                          busy_1,
    output logic                          busy_2,
    output logic                          stall_request,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int TIMER_W = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FORCE} state_t;

    state_t              state;
    logic [TIMER_W-1:0]  timer;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic                ready_q;
    logic [ADDR_W-1:0]   addr_mem [FIFO_DEPTH];
    logic [DATA_W-1:0]   data_mem [FIFO_DEPTH];

    logic                wb_write;
    logic                fifo_empty;
    logic                pop;
    logic                push;
    logic                blocked;
    logic [CNT_W-1:0]    count_next;
    logic [FIFO_DEPTH-1:0] entry_valid;

    assign wb_write   = wb_valid && (wb_addr != '0);
    assign fifo_empty = (fifo_count == '0);
    assign pop        = !wb_write && !fifo_empty;
    assign blocked    = wb_write && !fifo_empty;
    // Writes to r0 complete the handshake but are never queued.
    assign push       = mdu_valid && ready_q && (mdu_addr != '0);
    assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
    assign mdu_ready  = ready_q;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        entry_valid = '0;
        busy_1      = 1'b0;
        busy_2      = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            entry_valid[i] = {1'b0, PTR_W'(i) - rd_ptr} < fifo_count;
            if (entry_valid[i] && (addr_mem[i] == busy_addr_1) && (busy_addr_1 != '0))
                busy_1 = 1'b1;
            if (entry_valid[i] && (addr_mem[i] == busy_addr_2) && (busy_addr_2 != '0))
                busy_2 = 1'b1;
        end
    end

    // NOTE: storage has no reset; entry validity comes solely from fifo_count and rd_ptr.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem[wr_ptr] <= mdu_addr;
            data_mem[wr_ptr] <= mdu_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_write_enable  <= 1'b0;
            rf_write_address <= '0;
            rf_write_data    <= '0;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            fifo_count       <= '0;
            ready_q          <= 1'b0;
            state            <= ST_IDLE;
            timer            <= '0;
            stall_request    <= 1'b0;
        end else begin
            ready_q         <= (count_next < CNT_W'(FIFO_DEPTH));
            fifo_count      <= count_next;
            rf_write_enable <= wb_write || pop;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

            if (wb_write) begin
                rf_write_address <= wb_addr;
                rf_write_data    <= wb_data;
            end else if (pop) begin
                rf_write_address <= addr_mem[rd_ptr];
                rf_write_data    <= data_mem[rd_ptr];
            end

            case (state)
                ST_IDLE: begin
                    if (push) begin
                        state <= ST_WAIT;
                        timer <= '0;
                    end
                end
                ST_WAIT: begin
                    if (pop) begin
                        timer <= '0;
                        state <= (count_next == '0) ? ST_IDLE : ST_WAIT;
                    end else if (blocked) begin
                        if (timer == TIMER_W'(STARVE_LIMIT - 1)) begin
                            state         <= ST_FORCE;
                            stall_request <= 1'b1;
                        end else begin
                            timer <= timer + TIMER_W'(1);
                        end
                    end
                end
                ST_FORCE: begin
                    // A wb write that ignores the stall still wins; keep forcing.
                    if (pop) begin
                        timer         <= '0;
                        stall_request <= 1'b0;
                        state         <= (count_next == '0) ? ST_IDLE : ST_WAIT;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    timer         <= '0;
                    stall_request <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized scoreboard bench for regfile_write_arbiter against a queue-based reference model.
module tb_regfile_write_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;
    localparam int LIMIT  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              wb_valid = 1'b0;
    logic [ADDR_W-1:0] wb_addr = '0;
    logic [DATA_W-1:0] wb_data = '0;
    logic              mdu_valid = 1'b0;
    logic              mdu_ready;
    logic [ADDR_W-1:0] mdu_addr = '0;
    logic [DATA_W-1:0] mdu_data = '0;
    logic              rf_write_enable;
    logic [ADDR_W-1:0] rf_write_address;
    logic [DATA_W-1:0] rf_write_data;
    logic [ADDR_W-1:0] busy_addr_1 = '0;
    logic [ADDR_W-1:0] busy_addr_2 = '0;
    logic              busy_1;
    logic              busy_2;
    logic              stall_request;
    logic [CNT_W-1:0]  fifo_count;

    regfile_write_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clock(clock), .reset(reset),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
        .rf_write_enable(rf_write_enable), .rf_write_address(rf_write_address),
        .rf_write_data(rf_write_data),
        .busy_addr_1(busy_addr_1), .busy_addr_2(busy_addr_2), .busy_1(busy_1), .busy_2(busy_2),
        .stall_request(stall_request), .fifo_count(fifo_count)
    );

    always #5 clock = ~clock;

    wr_t model_fifo[$];
    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  starve   = 0;
    bit  started  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_busy(input logic [ADDR_W-1:0] a);
        if (a == '0) return 1'b0;
        foreach (model_fifo[i]) if (model_fifo[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: every write the DUT presents must match the oldest expected write.
    always @(posedge clock) begin
        #1;
        if (!reset && rf_write_enable) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual addr=%0d data=0x%0h required none at %0t",
                         rf_write_address, rf_write_data, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", rf_write_address, e.addr);
                check("write_data", rf_write_data, e.data);
            end
        end
    end

    // Reference model: pipeline wins, otherwise the oldest queued result drains.
    task automatic model_step();
        bit wb_w, pop, push;
        wb_w = wb_valid && (wb_addr != '0);
        push = mdu_valid && started && (model_fifo.size() < DEPTH) && (mdu_addr != '0);
        pop  = !wb_w && (model_fifo.size() != 0);
        if (model_fifo.size() == 0 || pop) starve = 0;
        else starve++;
        if (wb_w) exp_q.push_back('{wb_addr, wb_data});
        else if (pop) exp_q.push_back(model_fifo.pop_front());
        if (push) model_fifo.push_back('{mdu_addr, mdu_data});
        started = 1'b1;
    endtask

    task automatic check_state();
        check("fifo_count", fifo_count, model_fifo.size());
        check("mdu_ready", mdu_ready, started && (model_fifo.size() < DEPTH));
        check("stall_request", stall_request, starve >= LIMIT);
        check("pending_writes", exp_q.size(), 0);
    endtask

    task automatic drive(input int wb_pct, input int mdu_pct, input int zero_pct);
        wb_valid  = ($urandom_range(99) < wb_pct);
        wb_addr   = ($urandom_range(99) < zero_pct) ? '0 : ADDR_W'($urandom_range(31, 1));
        wb_data   = $urandom;
        mdu_valid = ($urandom_range(99) < mdu_pct);
        mdu_addr  = ($urandom_range(99) < zero_pct) ? '0 : ADDR_W'($urandom_range(31, 1));
        mdu_data  = $urandom;
        if (model_fifo.size() != 0 && $urandom_range(1) == 1)
            busy_addr_1 = model_fifo[model_fifo.size() - 1].addr;
        else
            busy_addr_1 = ADDR_W'($urandom_range(31));
        busy_addr_2 = ($urandom_range(3) == 0) ? '0 : ADDR_W'($urandom_range(31));
    endtask

    task automatic cycle(input int wb_pct, input int mdu_pct, input int zero_pct);
        @(negedge clock);
        check_state();
        drive(wb_pct, mdu_pct, zero_pct);
        #1;
        check("busy_1", busy_1, model_busy(busy_addr_1));
        check("busy_2", busy_2, model_busy(busy_addr_2));
        model_step();
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b0;
        drive(0, 100, 0);
        model_step();
    endtask

    initial begin
        #1;
        check("reset_we", rf_write_enable, 1'b0);
        check("reset_addr", rf_write_address, 0);
        check("reset_data", rf_write_data, 0);
        check("reset_count", fifo_count, 0);
        check("reset_ready", mdu_ready, 1'b0);
        check("reset_stall", stall_request, 1'b0);
        repeat (2) @(negedge clock);
        release_reset();

        repeat (300) cycle(50, 60, 10);
        repeat (300) cycle(95, 50, 5);
        repeat (200) cycle(10, 70, 10);

        for (int g = 0; g < 50 && model_fifo.size() != DEPTH; g++) cycle(100, 100, 0);
        @(negedge clock);
        check_state();
        busy_addr_1 = (model_fifo.size() != 0) ? model_fifo[0].addr : ADDR_W'(1);
        reset = 1'b1;
        #1;
        check("midreset_we", rf_write_enable, 1'b0);
        check("midreset_addr", rf_write_address, 0);
        check("midreset_data", rf_write_data, 0);
        check("midreset_count", fifo_count, 0);
        check("midreset_ready", mdu_ready, 1'b0);
        check("midreset_stall", stall_request, 1'b0);
        check("midreset_busy", busy_1, 1'b0);
        model_fifo.delete();
        exp_q.delete();
        starve  = 0;
        started = 1'b0;
        release_reset();

        repeat (200) cycle(50, 60, 10);
        @(negedge clock);
        check_state();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
